// File: rtl/vid_demux_if.sv
// vid_demux_if: source video stream in, N routed video streams plus switch status out.
//   pixel_in/h_sync_in/v_sync_in/de_in : source RGB stream and its active-high syncs
//   sw                                  : requested destination channel
//   pixel_out/h_sync_out/v_sync_out/de_out : per-channel routed stream, 1 clk latency
//   sel_out/switch_pending/switch_done  : active channel and switch status
interface vid_demux_if #(
  parameter int N        = 3,
  parameter int ADDR_LEN = $clog2(N)
);
  logic [23:0]         pixel_in;
  logic                h_sync_in;
  logic                v_sync_in;
  logic                de_in;
  logic [ADDR_LEN-1:0] sw;
  logic [N-1:0][23:0]  pixel_out;
  logic [N-1:0]        h_sync_out;
  logic [N-1:0]        v_sync_out;
  logic [N-1:0]        de_out;
  logic [ADDR_LEN-1:0] sel_out;
  logic                switch_pending;
  logic                switch_done;
  modport master (
    output pixel_in, h_sync_in, v_sync_in, de_in, sw,
    input  pixel_out, h_sync_out, v_sync_out, de_out, sel_out, switch_pending, switch_done
  );
  modport slave (
    input  pixel_in, h_sync_in, v_sync_in, de_in, sw,
    output pixel_out, h_sync_out, v_sync_out, de_out, sel_out, switch_pending, switch_done
  );
endinterface

// File: rtl/vid_demux.sv
// vid_demux: routes one video stream to one of N channels, switching only at frame start.
//   clk   : single clock
//   rst_n : asynchronous active-low reset
//   bus   : vid_demux_if slave (source stream and sw in; channel streams and status out)
module vid_demux #(
  parameter int N        = 3,
  parameter int ADDR_LEN = $clog2(N)
) (
  input logic        clk,
  input logic        rst_n,
  vid_demux_if.slave bus
);
  logic [ADDR_LEN-1:0] sw_q, sel_q, sel_d;
  logic                vs_prev_q, vs_rise, sw_valid, take;
  logic [N-1:0][23:0]  pixel_q, pixel_d;
  logic [N-1:0]        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic                pend_q, pend_d, done_q, done_d;
  always_comb begin
    vs_rise  = bus.v_sync_in & ~vs_prev_q;
    sw_valid = 32'(sw_q) < N;
    take     = vs_rise & sw_valid & (sw_q != sel_q);
    // the frame-start cycle already routes to the new channel so it sees the first v_sync sample
    sel_d    = take ? sw_q : sel_q;
    pend_d   = sw_valid & (sw_q != sel_d);
    done_d   = take;
    pixel_d  = '0;
    hs_d     = '0;
    vs_d     = '0;
    de_d     = '0;
    for (int k = 0; k < N; k++) begin
      pixel_d[k] = (ADDR_LEN'(k) == sel_d) ? bus.pixel_in : 24'h000000;
      hs_d[k]    = (ADDR_LEN'(k) == sel_d) & bus.h_sync_in;
      vs_d[k]    = (ADDR_LEN'(k) == sel_d) & bus.v_sync_in;
      de_d[k]    = (ADDR_LEN'(k) == sel_d) & bus.de_in;
    end
  end
  // vs_prev resets high so a v_sync already asserted at reset release is not a frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_q      <= '0;
      sel_q     <= '0;
      vs_prev_q <= 1'b1;
      pixel_q   <= '0;
      hs_q      <= '0;
      vs_q      <= '0;
      de_q      <= '0;
      pend_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      sw_q      <= bus.sw;
      sel_q     <= sel_d;
      vs_prev_q <= bus.v_sync_in;
      pixel_q   <= pixel_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      de_q      <= de_d;
      pend_q    <= pend_d;
      done_q    <= done_d;
    end
  end
  assign bus.pixel_out      = pixel_q;
  assign bus.h_sync_out     = hs_q;
  assign bus.v_sync_out     = vs_q;
  assign bus.de_out         = de_q;
  assign bus.sel_out        = sel_q;
  assign bus.switch_pending = pend_q;
  assign bus.switch_done    = done_q;
endmodule

// File: tb/tb_vid_demux.sv
// tb_vid_demux: directed frame-level checks of vid_demux routing and switching.
module tb_vid_demux;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int fid = 0;
  vid_demux_if #(.N(N)) vif ();
  vid_demux #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(vif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cyc(input int ch, input logic vs, input logic hs, input logic de, input logic [23:0] pix);
    logic [N-1:0][23:0] ep;
    logic [N-1:0] eh, ev, ed;
    vif.v_sync_in = vs;
    vif.h_sync_in = hs;
    vif.de_in     = de;
    vif.pixel_in  = pix;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      ep[k] = (k == ch) ? pix : 24'h000000;
      eh[k] = (k == ch) && hs;
      ev[k] = (k == ch) && vs;
      ed[k] = (k == ch) && de;
    end
    chk("pixel_out", 128'(vif.pixel_out), 128'(ep));
    chk("h_sync_out", 128'(vif.h_sync_out), 128'(eh));
    chk("v_sync_out", 128'(vif.v_sync_out), 128'(ev));
    chk("de_out", 128'(vif.de_out), 128'(ed));
  endtask
  // 2 v_sync cycles then 4 lines of (1 h_sync, 8 active pixels, 1 blank); sw may change at c1/c2
  task automatic frame(input int ch, input logic exp_done, input int c1, input logic [1:0] v1,
                       input logic exp_pend, input int c2, input logic [1:0] v2);
    for (int c = 0; c < 42; c++) begin
      if (c == c1) vif.sw = v1;
      if (c == c2) vif.sw = v2;
      cyc(ch, c < 2, (c >= 2) && ((c - 2) % 10 == 0),
          (c >= 2) && ((c - 2) % 10 >= 1) && ((c - 2) % 10 <= 8),
          24'h5A0000 | 24'(fid * 256 + c));
      chk("sel_out", 128'(vif.sel_out), 128'(ch));
      chk("switch_done", 128'(vif.switch_done), 128'((c == 0) ? exp_done : 1'b0));
      if (c1 >= 0 && c == c1) chk("pending_lag", 128'(vif.switch_pending), 128'(0));
      if (c1 >= 0 && c == c1 + 1) chk("pending", 128'(vif.switch_pending), 128'(exp_pend));
    end
    fid++;
  endtask
  task automatic chk_all_zero(input string tag);
    chk({tag, "_pixel"}, 128'(vif.pixel_out), 128'(0));
    chk({tag, "_sync_de"}, 128'({vif.h_sync_out, vif.v_sync_out, vif.de_out}), 128'(0));
    chk({tag, "_sel"}, 128'(vif.sel_out), 128'(0));
    chk({tag, "_pend_done"}, 128'({vif.switch_pending, vif.switch_done}), 128'(0));
  endtask
  initial begin
    rst_n = 1'b0;
    vif.sw = 2'd2;
    vif.pixel_in = 24'hFFFFFF;
    vif.h_sync_in = 1'b1;
    vif.v_sync_in = 1'b1;
    vif.de_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    vif.sw = 2'd0;
    vif.v_sync_in = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) cyc(0, 1'b0, 1'b0, 1'b0, 24'h123456);
    chk("idle_sel", 128'(vif.sel_out), 128'(0));
    frame(0, 1'b0, -1, 2'd0, 1'b0, -1, 2'd0);
    frame(0, 1'b0, 20, 2'd2, 1'b1, -1, 2'd0);
    chk("pending_hold", 128'(vif.switch_pending), 128'(1));
    frame(2, 1'b1, -1, 2'd0, 1'b0, -1, 2'd0);
    chk("pending_clear", 128'(vif.switch_pending), 128'(0));
    frame(2, 1'b0, 10, 2'd3, 1'b0, -1, 2'd0);
    frame(2, 1'b0, -1, 2'd0, 1'b0, -1, 2'd0);
    chk("invalid_pending", 128'(vif.switch_pending), 128'(0));
    frame(2, 1'b0, 0, 2'd1, 1'b1, -1, 2'd0);
    frame(1, 1'b1, -1, 2'd0, 1'b0, -1, 2'd0);
    frame(1, 1'b0, 5, 2'd0, 1'b1, -1, 2'd0);
    frame(0, 1'b1, -1, 2'd0, 1'b0, -1, 2'd0);
    frame(0, 1'b0, 5, 2'd1, 1'b1, 15, 2'd0);
    frame(0, 1'b0, -1, 2'd0, 1'b0, -1, 2'd0);
    chk("toggle_pending", 128'(vif.switch_pending), 128'(0));
    frame(0, 1'b0, 3, 2'd2, 1'b1, -1, 2'd0);
    frame(2, 1'b1, -1, 2'd0, 1'b0, -1, 2'd0);
    vif.sw = 2'd1;
    cyc(2, 1'b0, 1'b0, 1'b1, 24'hABCDEF);
    cyc(2, 1'b0, 1'b0, 1'b1, 24'hABCDF0);
    chk("pre_reset_pending", 128'(vif.switch_pending), 128'(1));
    vif.de_in = 1'b1;
    vif.v_sync_in = 1'b1;
    vif.sw = 2'd2;
    rst_n = 1'b0;
    #2;
    chk_all_zero("async_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 1'b1, 1'b0, 1'b1, 24'h010203);
    chk("release_sel", 128'(vif.sel_out), 128'(0));
    cyc(0, 1'b1, 1'b0, 1'b0, 24'h040506);
    chk("release_pending", 128'(vif.switch_pending), 128'(1));
    repeat (3) begin
      cyc(0, 1'b1, 1'b0, 1'b0, 24'h070809);
      chk("release_done", 128'(vif.switch_done), 128'(0));
      chk("release_hold", 128'(vif.sel_out), 128'(0));
    end
    cyc(0, 1'b0, 1'b0, 1'b0, 24'h0A0B0C);
    frame(2, 1'b1, -1, 2'd0, 1'b0, -1, 2'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vid_demux.md
VID_DEMUX -- requirements
Module: vid_demux

Interface
REQ-001 Parameter N, default 3: number of output video channels; legal range 2..16.
REQ-002 Parameter ADDR_LEN, default $clog2(N): width of the channel select.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pixel_in  input  24  RGB pixel of the source stream.
REQ-006 h_sync_in  input  1  horizontal sync of the source stream, active-high.
REQ-007 v_sync_in  input  1  vertical sync of the source stream, active-high.
REQ-008 de_in  input  1  data enable of the source stream, active-high.
REQ-009 sw  input  ADDR_LEN  requested destination channel.
REQ-010 pixel_out  output  [N-1:0][23:0]  per-channel pixel.
REQ-011 h_sync_out  output  N  per-channel h_sync.
REQ-012 v_sync_out  output  N  per-channel v_sync.
REQ-013 de_out  output  N  per-channel data enable.
REQ-014 sel_out  output  ADDR_LEN  currently active channel.
REQ-015 switch_pending  output  1  high while a valid request differs from sel_out.
REQ-016 switch_done  output  1  one-cycle pulse in the cycle sel_out takes a new value.

Function
REQ-017 sw SHALL be registered once (sw_q) before use; only sw_q drives selection logic.
REQ-018 A frame start (vs_rise) SHALL be v_sync_in=1 in the current cycle with vs_prev=0, where vs_prev is v_sync_in registered.
REQ-019 On vs_rise with sw_q<N and sw_q!=sel, sel SHALL load sw_q at the next clock edge and switch_done SHALL pulse high for exactly that one cycle.
REQ-020 sw_q>=N SHALL be ignored: sel is held and switch_pending stays 0.
REQ-021 sel SHALL never change outside a vs_rise cycle, whatever sw does mid-frame.
REQ-022 Routing in the vs_rise cycle SHALL use the new selection, so the new channel receives the whole frame including its first v_sync sample.
REQ-023 All data outputs SHALL be registered with a latency of exactly 1 clock from input to output.
REQ-024 Channel k==active selection SHALL output pixel_in, h_sync_in, v_sync_in and de_in delayed by one cycle.
REQ-025 Every other channel SHALL output pixel 24'h000000 with h_sync, v_sync and de all 0.
REQ-026 switch_pending SHALL be registered: 1 when sw_q<N and sw_q!=sel, else 0.
REQ-027 A sw change in the same cycle as vs_rise SHALL NOT take effect until the following frame, because sw_q still holds the old value.
REQ-028 If sw returns to the current sel before the next vs_rise, no switch SHALL occur and switch_done SHALL stay 0.

Reset
REQ-029 While rst_n=0 these SHALL be 0: sel, sw_q, sel_out, all pixel_out, h_sync_out, v_sync_out, de_out, switch_pending and switch_done.
REQ-030 vs_prev SHALL reset to 1, so v_sync_in already high at reset release creates no frame start.
REQ-031 Reset asserted mid-frame SHALL take effect immediately; after release, channel 0 is routed from the first clock edge.

Verification
REQ-032 Reset release, sw=0, 2 frames of 8x4 active pixels -> channel 0 mirrors the input delayed 1 clk; channels 1..2 stay all-zero.
REQ-033 sw=2 set mid-frame -> switch_pending=1 from 2 clks later; sel_out stays 0 until the next v_sync_in rise. The clock after that rise: sel_out=2 and switch_done is a one-cycle pulse. Channel 2 gets the full next frame; channel 0 is zero from that cycle on.
REQ-034 sw=3 with N=3 -> switch_pending=0, no vs_rise changes sel_out, and channel routing is unchanged.
REQ-035 sw changed to 1 in the same cycle as the v_sync_in rise -> no switch at that frame; switch happens at the following frame start.
REQ-036 v_sync_in=1 at reset release -> no switch_done and no selection change until the next 0->1 transition.
REQ-037 sw toggles 0->1->0 within one frame -> switch_done never asserts and sel_out stays 0.
